// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame sequencer for the UART receiver.
// Runs on the oversampling clock. Walks each frame through start, eight data
// bits, an optional parity bit and the stop bit. Also drives the enables for
// the sampler, deserializer and parity checker, and reports the frame result
// as one-cycle pulses.
module uart_rx_ctrl #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  sampled_bit,
    input  logic                  par_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  data_valid,
    output logic                  par_error,
    output logic                  stp_error,
    output logic                  strt_glitch
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [PRESCALE_W-1:0] EDGE_ONE = 1;
    localparam logic [3:0]            LAST_DATA_BIT = 4'd8;

    state_t                  state_reg;
    logic [PRESCALE_W-1:0]   edge_cnt_reg;
    logic [3:0]              bit_cnt_reg;
    // Prescale and parity mode are frozen at the start edge so that changes
    // mid-frame cannot disturb the bit timing.
    logic [PRESCALE_W-1:0]   p_reg;
    logic                    pe_reg;
    logic                    par_flag_reg;
    logic                    data_valid_reg;
    logic                    par_error_reg;
    logic                    stp_error_reg;
    logic                    strt_glitch_reg;
    logic                    bit_end;

    // Last oversampling edge of the current bit.
    assign bit_end = (state_reg != IDLE) && (edge_cnt_reg == (p_reg - EDGE_ONE));

    // Sequencer: counters, latched frame parameters, state and result pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg       <= IDLE;
            edge_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            p_reg           <= '0;
            pe_reg          <= 1'b0;
            par_flag_reg    <= 1'b0;
            data_valid_reg  <= 1'b0;
            par_error_reg   <= 1'b0;
            stp_error_reg   <= 1'b0;
            strt_glitch_reg <= 1'b0;
        end else begin
            // Result outputs are single-cycle pulses.
            data_valid_reg  <= 1'b0;
            par_error_reg   <= 1'b0;
            stp_error_reg   <= 1'b0;
            strt_glitch_reg <= 1'b0;

            if (state_reg == IDLE) begin
                edge_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
            end else if (bit_end) begin
                edge_cnt_reg <= '0;
                bit_cnt_reg  <= bit_cnt_reg + 4'd1;
            end else begin
                edge_cnt_reg <= edge_cnt_reg + EDGE_ONE;
            end

            case (state_reg)
                IDLE: begin
                    p_reg        <= Prescale;
                    pe_reg       <= PAR_EN;
                    par_flag_reg <= 1'b0;
                    if (!RX_IN) begin
                        state_reg <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        if (sampled_bit) begin
                            // Line went back high: treat as noise, not a frame.
                            strt_glitch_reg <= 1'b1;
                            state_reg       <= IDLE;
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_end && (bit_cnt_reg == LAST_DATA_BIT)) begin
                        state_reg <= pe_reg ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_flag_reg <= par_err;
                        state_reg    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        stp_error_reg  <= ~sampled_bit;
                        par_error_reg  <= par_flag_reg;
                        data_valid_reg <= sampled_bit & ~par_flag_reg;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Sampler runs through the whole frame; the shift strobe and the parity
    // check enable are decoded directly from state and counters.
    assign dat_samp_en = (state_reg != IDLE);
    assign deser_en    = (state_reg == DATA) && bit_end;
    assign par_chk_en  = (state_reg == PARITY);

    assign edge_cnt    = edge_cnt_reg;
    assign bit_cnt     = bit_cnt_reg;
    assign data_valid  = data_valid_reg;
    assign par_error   = par_error_reg;
    assign stp_error   = stp_error_reg;
    assign strt_glitch = strt_glitch_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl. A behavioural frame model computes expected
// pulse counts and timings from the bit period P and the frame length N.
module tb_uart_rx_ctrl;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic [PW-1:0] Prescale = 6'd8;
    logic          sampled_bit = 1'b1;
    logic          par_err = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en, deser_en, par_chk_en;
    logic          data_valid, par_error, stp_error, strt_glitch;

    uart_rx_ctrl #(.PRESCALE_W(PW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
        .Prescale(Prescale), .sampled_bit(sampled_bit), .par_err(par_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .deser_en(deser_en), .par_chk_en(par_chk_en), .data_valid(data_valid),
        .par_error(par_error), .stp_error(stp_error), .strt_glitch(strt_glitch)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Observation counters, updated once per cycle away from the active edge.
    int n_deser = 0, n_parchk = 0, n_parchk9 = 0, n_dv = 0;
    int n_pe = 0, n_se = 0, n_sg = 0, n_busy = 0;
    int last_dv = -1, last_sg = -1;
    int dv_q[$];
    logic [7:0] shreg = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST) begin
            if (deser_en) begin
                n_deser <= n_deser + 1;
                shreg   <= {sampled_bit, shreg[7:1]};
            end
            if (par_chk_en) begin
                n_parchk <= n_parchk + 1;
                if (bit_cnt == 4'd9) n_parchk9 <= n_parchk9 + 1;
            end
            if (data_valid) begin
                n_dv    <= n_dv + 1;
                last_dv <= cyc;
                dv_q.push_back(cyc);
            end
            if (par_error)   n_pe <= n_pe + 1;
            if (stp_error)   n_se <= n_se + 1;
            if (strt_glitch) begin
                n_sg    <= n_sg + 1;
                last_sg <= cyc;
            end
            if ((data_valid | par_error | stp_error) && dat_samp_en) n_busy <= n_busy + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one frame bit-by-bit; sampled_bit mirrors the bit being sent.
    task automatic run_frame(input int p, input int pe, input logic [7:0] data,
                             input bit stop, input bit perr, input bit glitch,
                             input bit chg, input int probe_j, input int abort_j,
                             output int t_start);
        logic bits [0:10];
        int   nb, last_j, k;
        logic rx, sb;
        nb = 10 + pe;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        bits[9]  = (pe != 0) ? ^data : stop;
        bits[10] = stop;
        last_j = glitch ? p : nb * p;
        t_start = cyc;
        Prescale = p[PW-1:0];
        PAR_EN   = (pe != 0);
        par_err  = perr;
        for (int j = 0; j <= last_j; j++) begin
            if (j == 0) begin
                rx = 1'b0; sb = 1'b0;
            end else if (glitch) begin
                rx = (j < 2) ? 1'b0 : 1'b1; sb = 1'b1;
            end else begin
                k = (j - 1) / p;
                rx = bits[k]; sb = bits[k];
            end
            if (chg && j == 3 * p) begin
                Prescale = 6'd32;
                PAR_EN   = 1'b1;
            end
            RX_IN = rx;
            sampled_bit = sb;
            @(posedge CLK); #1;
            if (j == probe_j) begin
                chk("edge_cnt", int'(edge_cnt), j % p);
                chk("bit_cnt", int'(bit_cnt), j / p);
            end
            if (j == abort_j) begin
                chk("pre_reset_deser", int'(deser_en), 1);
                RST = 1'b0;
                #1;
                chk("reset_outputs", int'({edge_cnt, bit_cnt, dat_samp_en, deser_en, par_chk_en,
                                            data_valid, par_error, stp_error, strt_glitch}), 0);
                break;
            end
        end
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
    endtask

    // One isolated frame plus the full set of per-frame comparisons.
    task automatic do_frame(input int p, input int pe, input logic [7:0] data,
                            input bit stop, input bit perr, input bit glitch, input bit chg);
        int s_deser, s_parchk, s_parchk9, s_dv, s_pe, s_se, s_sg, s_busy;
        int nb, last_j, probe, t, exp_dv;
        s_deser = n_deser; s_parchk = n_parchk; s_parchk9 = n_parchk9; s_dv = n_dv;
        s_pe = n_pe; s_se = n_se; s_sg = n_sg; s_busy = n_busy;
        nb = 10 + pe;
        last_j = glitch ? p : nb * p;
        probe = $urandom_range(0, last_j - 1);
        run_frame(p, pe, data, stop, perr, glitch, chg, probe, -1, t);
        repeat (2) @(posedge CLK);
        #1;
        exp_dv = (!glitch && stop && !(pe != 0 && perr)) ? 1 : 0;
        chk("deser_cnt", n_deser - s_deser, glitch ? 0 : 8);
        chk("parchk_cnt", n_parchk - s_parchk, (pe != 0 && !glitch) ? p : 0);
        chk("parchk_bit9", n_parchk9 - s_parchk9, (pe != 0 && !glitch) ? p : 0);
        chk("data_valid_cnt", n_dv - s_dv, exp_dv);
        chk("par_error_cnt", n_pe - s_pe, (!glitch && pe != 0 && perr) ? 1 : 0);
        chk("stp_error_cnt", n_se - s_se, (!glitch && !stop) ? 1 : 0);
        chk("strt_glitch_cnt", n_sg - s_sg, glitch ? 1 : 0);
        chk("pulse_while_busy", n_busy - s_busy, 0);
        chk("idle_after", int'(dat_samp_en), 0);
        if (!glitch) chk("rx_byte", int'(shreg), int'(data));
        if (exp_dv != 0) chk("dv_time", last_dv, t + 1 + nb * p);
        if (glitch) chk("sg_time", last_sg, t + 1 + p);
        $display("frame P=%0d PE=%0d data=%02h stop=%0d perr=%0d glitch=%0d chg=%0d",
                 p, pe, data, stop, perr, glitch, chg);
    endtask

    initial begin
        int t1, t2, s_dv, s_any, psel;
        int plist [3];
        plist[0] = 8; plist[1] = 16; plist[2] = 32;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_state", int'({edge_cnt, bit_cnt, dat_samp_en, deser_en, par_chk_en,
                                 data_valid, par_error, stp_error, strt_glitch}), 0);
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        // Directed frames
        do_frame(8, 0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        do_frame(16, 1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        do_frame(16, 1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        do_frame(16, 1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame(8, 0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        do_frame(8, 0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame during DATA, bit_cnt = 4, on a deser_en cycle
        s_dv  = n_dv;
        s_any = n_pe + n_se + n_sg;
        run_frame(8, 0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 35, 39, t1);
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (100) @(posedge CLK);
        #1;
        chk("no_dv_after_reset", n_dv - s_dv, 0);
        chk("no_pulse_after_reset", n_pe + n_se + n_sg - s_any, 0);
        $display("reset mid-frame at bit_cnt=4");

        // Back-to-back frames at minimum spacing
        s_dv = n_dv;
        dv_q.delete();
        run_frame(8, 0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 20, -1, t1);
        run_frame(8, 0, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 30, -1, t2);
        repeat (2) @(posedge CLK);
        #1;
        chk("b2b_dv_cnt", n_dv - s_dv, 2);
        chk("b2b_start_gap", t2 - t1, 81);
        if (dv_q.size() == 2) begin
            chk("b2b_dv_first", dv_q[0], t1 + 81);
            chk("b2b_dv_spacing", dv_q[1] - dv_q[0], 81);
        end
        chk("b2b_byte2", int'(shreg), 8'h7E);
        $display("back-to-back frames t1=%0d t2=%0d", t1, t2);

        // Randomized frames
        for (int n = 0; n < 10; n++) begin
            psel = $urandom_range(0, 2);
            do_frame(plist[psel], $urandom_range(0, 1), 8'($urandom),
                     ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
